// File: rtl/generic_sram_byte_en_arb.sv
// Two-port round-robin arbiter in front of a single-port, byte-enable,
// synchronous-read SRAM. Read data returns one cycle after acceptance.
module generic_sram_byte_en_arb #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDRESS_WIDTH = 7
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [1:0]                    i_req_valid,
  output logic [1:0]                    o_req_ready,
  input  logic [1:0]                    i_req_write,
  input  logic [2*ADDRESS_WIDTH-1:0]    i_req_address,
  input  logic [2*(DATA_WIDTH/8)-1:0]   i_req_byte_enable,
  input  logic [2*DATA_WIDTH-1:0]       i_req_write_data,
  output logic [1:0]                    o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_read_data,
  output logic                          o_sram_write_enable,
  output logic [ADDRESS_WIDTH-1:0]      o_sram_address,
  output logic [DATA_WIDTH/8-1:0]       o_sram_byte_enable,
  output logic [DATA_WIDTH-1:0]         o_sram_write_data,
  input  logic [DATA_WIDTH-1:0]         i_sram_read_data
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [1:0][ADDRESS_WIDTH-1:0] addr;
  logic [1:0][BE_W-1:0]          be;
  logic [1:0][DATA_WIDTH-1:0]    wdata;

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign addr[p]  = i_req_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign be[p]    = i_req_byte_enable[p*BE_W +: BE_W];
    assign wdata[p] = i_req_write_data[p*DATA_WIDTH +: DATA_WIDTH];
  end

  logic       prio;
  logic [1:0] rd_pend;
  logic [1:0] valid;
  logic       gnt_any;
  logic       gnt;

  // Reset masks requests so nothing is granted or written while held.
  assign valid   = i_req_valid & {2{i_rst_n}};
  assign gnt_any = |valid;
  assign gnt     = (&valid) ? prio : valid[1];

  always_comb begin
    o_req_ready         = '0;
    o_sram_write_enable = 1'b0;
    o_sram_address      = '0;
    o_sram_byte_enable  = '0;
    o_sram_write_data   = '0;
    if (gnt_any) begin
      o_req_ready[gnt]    = 1'b1;
      o_sram_write_enable = i_req_write[gnt];
      o_sram_address      = addr[gnt];
      o_sram_byte_enable  = be[gnt];
      o_sram_write_data   = wdata[gnt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prio    <= 1'b0;
      rd_pend <= '0;
    end else begin
      rd_pend <= '0;
      if (gnt_any) begin
        prio <= ~gnt;
        if (!i_req_write[gnt]) rd_pend[gnt] <= 1'b1;
      end
    end
  end

  // Response is also masked by reset so a read accepted just before reset is dropped.
  assign o_rsp_valid     = rd_pend & {2{i_rst_n}};
  assign o_rsp_read_data = (i_rst_n && (|rd_pend)) ? i_sram_read_data : '0;

endmodule

// File: tb/tb_generic_sram_byte_en_arb.sv
// Directed table-driven bench with a behavioural byte-enable SRAM model
// (synchronous read, read-before-write, zero read data on write cycles).
module tb_generic_sram_byte_en_arb;
  localparam int DW  = 128;
  localparam int AW  = 7;
  localparam int BEW = DW / 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [1:0]        i_req_valid;
  logic [1:0]        o_req_ready;
  logic [1:0]        i_req_write;
  logic [2*AW-1:0]   i_req_address;
  logic [2*BEW-1:0]  i_req_byte_enable;
  logic [2*DW-1:0]   i_req_write_data;
  logic [1:0]        o_rsp_valid;
  logic [DW-1:0]     o_rsp_read_data;
  logic              o_sram_write_enable;
  logic [AW-1:0]     o_sram_address;
  logic [BEW-1:0]    o_sram_byte_enable;
  logic [DW-1:0]     o_sram_write_data;
  logic [DW-1:0]     i_sram_read_data;

  generic_sram_byte_en_arb #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_address(i_req_address),
    .i_req_byte_enable(i_req_byte_enable), .i_req_write_data(i_req_write_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_read_data(o_rsp_read_data),
    .o_sram_write_enable(o_sram_write_enable), .o_sram_address(o_sram_address),
    .o_sram_byte_enable(o_sram_byte_enable), .o_sram_write_data(o_sram_write_data),
    .i_sram_read_data(i_sram_read_data)
  );

  always #5 i_clk = ~i_clk;

  // SRAM model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    i_sram_read_data = '0;
  end
  always @(posedge i_clk) begin
    if (o_sram_write_enable) begin
      for (int b = 0; b < BEW; b++)
        if (o_sram_byte_enable[b]) mem[o_sram_address][b*8 +: 8] <= o_sram_write_data[b*8 +: 8];
      i_sram_read_data <= '0;
    end else begin
      i_sram_read_data <= mem[o_sram_address];
    end
  end

  typedef struct {
    logic          rst_n;
    logic [1:0]    valid;
    logic [1:0]    write;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [BEW-1:0] be;
    logic [DW-1:0] wd;
    logic [1:0]    exp_ready;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_rsp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic rst_n, logic [1:0] valid, logic [1:0] write,
                              logic [AW-1:0] a0, logic [AW-1:0] a1, logic [BEW-1:0] be,
                              logic [DW-1:0] wd, logic [1:0] er, logic ewe,
                              logic [AW-1:0] ea, logic [1:0] ersp, logic [DW-1:0] erd);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.write = write; v.a0 = a0; v.a1 = a1;
    v.be = be; v.wd = wd; v.exp_ready = er; v.exp_we = ewe; v.exp_addr = ea;
    v.exp_rsp = ersp; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    i_rst_n           = v.rst_n;
    i_req_valid       = v.valid;
    i_req_write       = v.write;
    i_req_address     = {v.a1, v.a0};
    i_req_byte_enable = {v.be, v.be};
    i_req_write_data  = {v.wd, v.wd};
  endtask

  localparam logic [DW-1:0] D1 = 128'h1111_0001;
  localparam logic [DW-1:0] D2 = 128'h2222_0002;

  initial begin
    i_rst_n = 1'b0; i_req_valid = '0; i_req_write = '0; i_req_address = '0;
    i_req_byte_enable = '0; i_req_write_data = '0;

    //              rst valid   write   a0 a1 be        wd              ready  we ea rsp    rdata
    vecs.push_back(mk(0, 2'b11, 2'b11, 5, 6, 16'hFFFF, 128'h1,         2'b00, 0, 0, 2'b00, '0));   // 0 reset masks
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 16'h0,    '0,             2'b00, 0, 0, 2'b00, '0));   // 1 idle
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 16'h0,    '0,             2'b00, 0, 0, 2'b00, '0));   // 2 idle
    vecs.push_back(mk(1, 2'b01, 2'b01, 5, 0, 16'hFFFF, 128'hDEADBEEF,  2'b01, 1, 5, 2'b00, '0));   // 3 p0 wr 5
    vecs.push_back(mk(1, 2'b01, 2'b00, 5, 0, 16'hFFFF, '0,             2'b01, 0, 5, 2'b00, '0));   // 4 p0 rd 5
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 16'h0,    '0,             2'b00, 0, 0, 2'b01, 128'hDEADBEEF));
    vecs.push_back(mk(1, 2'b01, 2'b01, 1, 0, 16'hFFFF, D1,             2'b01, 1, 1, 2'b00, '0));   // 6 wr 1
    vecs.push_back(mk(1, 2'b10, 2'b10, 0, 2, 16'hFFFF, D2,             2'b10, 1, 2, 2'b00, '0));   // 7 wr 2 (prio 0 after)
    vecs.push_back(mk(1, 2'b11, 2'b00, 1, 2, 16'h0,    '0,             2'b01, 0, 1, 2'b00, '0));   // 8 contention
    vecs.push_back(mk(1, 2'b11, 2'b00, 1, 2, 16'h0,    '0,             2'b10, 0, 2, 2'b01, D1));
    vecs.push_back(mk(1, 2'b11, 2'b00, 1, 2, 16'h0,    '0,             2'b01, 0, 1, 2'b10, D2));
    vecs.push_back(mk(1, 2'b11, 2'b00, 1, 2, 16'h0,    '0,             2'b10, 0, 2, 2'b01, D1));
    vecs.push_back(mk(1, 2'b11, 2'b00, 1, 2, 16'h0,    '0,             2'b01, 0, 1, 2'b10, D2));
    vecs.push_back(mk(1, 2'b11, 2'b00, 1, 2, 16'h0,    '0,             2'b10, 0, 2, 2'b01, D1));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 16'h0,    '0,             2'b00, 0, 0, 2'b10, D2));   // 14
    vecs.push_back(mk(1, 2'b01, 2'b01, 3, 0, 16'hFFFF, 128'h11223344,  2'b01, 1, 3, 2'b00, '0));   // 15
    vecs.push_back(mk(1, 2'b01, 2'b01, 3, 0, 16'h0001, 128'hAA,        2'b01, 1, 3, 2'b00, '0));   // 16 partial
    vecs.push_back(mk(1, 2'b01, 2'b00, 3, 0, 16'h0,    '0,             2'b01, 0, 3, 2'b00, '0));   // 17
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 16'h0,    '0,             2'b00, 0, 0, 2'b01, 128'h112233AA));
    vecs.push_back(mk(1, 2'b10, 2'b00, 0, 3, 16'h0,    '0,             2'b10, 0, 3, 2'b00, '0));   // 19 p1 rd 3
    vecs.push_back(mk(1, 2'b01, 2'b01, 3, 0, 16'hFFFF, 128'h55,        2'b01, 1, 3, 2'b10, 128'h112233AA)); // old data
    vecs.push_back(mk(1, 2'b01, 2'b00, 3, 0, 16'h0,    '0,             2'b01, 0, 3, 2'b00, '0));   // 21 no rsp for wr
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 16'h0,    '0,             2'b00, 0, 0, 2'b01, 128'h55));
    vecs.push_back(mk(1, 2'b10, 2'b00, 0, 1, 16'h0,    '0,             2'b10, 0, 1, 2'b00, '0));   // 23 p1 rd
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 16'h0,    '0,             2'b00, 0, 0, 2'b00, '0));   // 24 dropped
    vecs.push_back(mk(1, 2'b11, 2'b00, 1, 2, 16'h0,    '0,             2'b01, 0, 1, 2'b00, '0));   // 25 p0 wins
    vecs.push_back(mk(1, 2'b10, 2'b00, 0, 2, 16'h0,    '0,             2'b10, 0, 2, 2'b01, D1));   // 26 p1 only
    vecs.push_back(mk(1, 2'b10, 2'b00, 0, 2, 16'h0,    '0,             2'b10, 0, 2, 2'b10, D2));
    vecs.push_back(mk(1, 2'b10, 2'b00, 0, 2, 16'h0,    '0,             2'b10, 0, 2, 2'b10, D2));
    vecs.push_back(mk(1, 2'b10, 2'b00, 0, 2, 16'h0,    '0,             2'b10, 0, 2, 2'b10, D2));
    vecs.push_back(mk(1, 2'b11, 2'b00, 1, 2, 16'h0,    '0,             2'b01, 0, 1, 2'b10, D2));   // 30 prio 0
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 16'h0,    '0,             2'b00, 0, 0, 2'b01, D1));
    vecs.push_back(mk(1, 2'b01, 2'b01, 1, 0, 16'h0,    {DW{1'b1}},     2'b01, 1, 1, 2'b00, '0));   // 32 be=0 write
    vecs.push_back(mk(1, 2'b01, 2'b00, 1, 0, 16'h0,    '0,             2'b01, 0, 1, 2'b00, '0));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 16'h0,    '0,             2'b00, 0, 0, 2'b01, D1));   // unchanged

    foreach (vecs[i]) begin
      @(negedge i_clk);
      drive(vecs[i]);
      #1;
      chk("ready",    i, DW'(o_req_ready),         DW'(vecs[i].exp_ready));
      chk("sram_we",  i, DW'(o_sram_write_enable), DW'(vecs[i].exp_we));
      chk("sram_addr",i, DW'(o_sram_address),      DW'(vecs[i].exp_addr));
      chk("rsp_valid",i, DW'(o_rsp_valid),         DW'(vecs[i].exp_rsp));
      chk("rsp_data", i, o_rsp_read_data,          vecs[i].exp_rdata);
    end

    // Both ports writing continuously; last accept was port0 so port1 leads.
    begin
      logic [1:0] exp_g;
      exp_g = 2'b10;
      for (int c = 0; c < 4; c++) begin
        @(negedge i_clk);
        i_rst_n = 1'b1; i_req_valid = 2'b11; i_req_write = 2'b11;
        i_req_address = {7'd11, 7'd10}; i_req_byte_enable = '1;
        i_req_write_data = {128'hB, 128'hA};
        #1;
        chk("alt_ready", 100 + c, DW'(o_req_ready), DW'(exp_g));
        chk("alt_data",  100 + c, o_sram_write_data, (exp_g == 2'b10) ? 128'hB : 128'hA);
        exp_g = ~exp_g;
      end
      @(negedge i_clk);
      i_req_valid = '0; i_req_write = '0;
      #1;
      chk("idle_be", 104, DW'(o_sram_byte_enable), '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
